// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one urat_tx byte transmitter between NUM_REQ on-chip byte producers.
// In IDLE, a round-robin search starting after the last winner picks one
// requester. Its byte is captured, acknowledged and handed to the transmitter
// with a one-cycle send strobe. Further grants are then held off for
// FRAME_CYCLES clocks so the transmitter can finish shifting the frame.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset (shared with urat_tx)
//   req       in   [NUM_REQ]   per-requester request level
//   data      in   [8*NUM_REQ] byte of requester i on data[8*i+7:8*i]
//   ack       out  [NUM_REQ]   one-cycle pulse, byte of requester i captured
//   send      out  one-cycle start strobe to urat_tx, coincident with ack
//   tx        out  [8]         byte to urat_tx, held until the next grant
//   grant_id  out  index of the last granted requester
//   busy      out  high while a frame is reserved
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int FRAME_CYCLES = 100
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       data,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       send,
    output logic [7:0]                 tx,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(FRAME_CYCLES);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic              send_q, send_d;
    logic [7:0]        tx_q, tx_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              busy_q, busy_d;

    logic              found;
    logic [ID_W-1:0]   win_id;

    // Round-robin search: candidates last+1, last+2, ... wrapping modulo
    // NUM_REQ, so the previous winner is examined last.
    always_comb begin
        found  = 1'b0;
        win_id = last_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int c;
            c = int'(last_q) + i;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            if (!found && req[ID_W'(c)]) begin
                found  = 1'b1;
                win_id = ID_W'(c);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        ack_d      = '0;
        send_d     = 1'b0;
        tx_d       = tx_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    ack_d      = NUM_REQ'(1) << win_id;
                    send_d     = 1'b1;
                    tx_d       = data[8*win_id +: 8];
                    grant_id_d = win_id;
                    last_d     = win_id;
                    busy_d     = 1'b1;
                    cnt_d      = CNT_W'(FRAME_CYCLES - 1);
                    state_d    = S_WAIT;
                end
            end
            default: begin
                // Requests are ignored for the whole reserved frame.
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            // Pointer at the top index so requester 0 wins first after reset.
            last_q     <= ID_W'(NUM_REQ - 1);
            ack_q      <= '0;
            send_q     <= 1'b0;
            tx_q       <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            ack_q      <= ack_d;
            send_q     <= send_d;
            tx_q       <= tx_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign send     = send_q;
    assign tx       = tx_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int FC      = 20;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [31:0]  data;
    logic [3:0]   ack;
    logic         send;
    logic [7:0]   tx;
    logic [1:0]   grant_id;
    logic         busy;

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .FRAME_CYCLES(FC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .data    (data),
        .ack     (ack),
        .send    (send),
        .tx      (tx),
        .grant_id(grant_id),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         prev_send = -1;
    int         busy_run = 0;
    bit         chk_spacing = 1'b0;
    bit         chk_busy_len = 1'b1;
    bit         saw_send = 1'b0;
    logic [7:0] exp_tx = 8'h00;
    int         exp_gid = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input logic [7:0] val);
        exp_t e;
        e.id  = id;
        e.val = val;
        sb.push_back(e);
    endtask

    // One clock, sampled 1 time unit after the rising edge; every send is
    // matched against the scoreboard, every other cycle must hold outputs.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        saw_send = send;
        if (send) begin
            if (sb.size() == 0) begin
                chk("unexpected_send", 32'(send), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("ack", 32'(ack), 32'(1) << e.id);
                chk("tx", 32'(tx), 32'(e.val));
                chk("grant_id", 32'(grant_id), 32'(e.id));
                chk("busy_at_send", 32'(busy), 32'(1));
                exp_tx  = e.val;
                exp_gid = e.id;
            end
            if (chk_spacing && prev_send >= 0) begin
                chk("send_spacing", 32'(cyc - prev_send), 32'(FC + 1));
            end
            prev_send = cyc;
        end else begin
            chk("ack_quiet", 32'(ack), 32'(0));
            chk("tx_hold", 32'(tx), 32'(exp_tx));
            chk("gid_hold", 32'(grant_id), 32'(exp_gid));
        end
        if (busy) begin
            busy_run++;
        end else begin
            if (busy_run != 0 && chk_busy_len) begin
                chk("busy_len", 32'(busy_run), 32'(FC));
            end
            busy_run = 0;
        end
    endtask

    task automatic wait_send(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (saw_send) return;
        end
        chk("timeout_send", 32'(0), 32'(1));
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) return;
            tick();
        end
        chk("timeout_idle", 32'(busy), 32'(0));
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b1111;
        data = {8'h43, 8'h32, 8'h21, 8'h10};

        // Reset held two cycles with every requester asking.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_ack", 32'(ack), 32'(0));
            chk("rst_send", 32'(send), 32'(0));
            chk("rst_tx", 32'(tx), 32'(0));
            chk("rst_gid", 32'(grant_id), 32'(0));
            chk("rst_busy", 32'(busy), 32'(0));
        end

        // Simultaneous requests, each dropped once acked.
        push(0, 8'h10);
        push(1, 8'h21);
        push(2, 8'h32);
        push(3, 8'h43);
        chk_spacing = 1'b1;
        rst = 1'b0;
        tick();
        chk("first_grant_latency", 32'(saw_send), 32'(1));
        req[0] = 1'b0;
        for (int g = 1; g < 4; g++) begin
            wait_send(3 * FC);
            req[g] = 1'b0;
        end
        wait_idle(3 * FC);

        // Fairness between requesters 0 and 3 held continuously.
        data = {8'hA3, 8'h00, 8'h00, 8'hA0};
        for (int g = 0; g < 3; g++) begin
            push(0, 8'hA0);
            push(3, 8'hA3);
        end
        req = 4'b1001;
        for (int g = 0; g < 6; g++) begin
            wait_send(3 * FC);
        end
        req = 4'b0000;
        chk_spacing = 1'b0;
        wait_idle(3 * FC);

        // Single request from requester 2, one-clock latency.
        data = {8'h00, 8'h67, 8'h00, 8'h00};
        push(2, 8'h67);
        req = 4'b0100;
        tick();
        chk("single_latency", 32'(saw_send), 32'(1));
        req = 4'b0000;

        // Requests inside WAIT: a short pulse on 2 is ignored, 1 waits.
        for (int i = 0; i < 3; i++) tick();
        data = {8'h00, 8'h99, 8'h5A, 8'h00};
        req  = 4'b0100;
        for (int i = 0; i < 3; i++) tick();
        req = 4'b0010;
        push(1, 8'h5A);
        wait_idle(3 * FC);
        chk("idle_no_ack", 32'(ack), 32'(0));
        tick();
        chk("ack_after_busy_falls", 32'(saw_send), 32'(1));
        req = 4'b0000;

        // Reset when the frame counter reads 10 (9 cycles after send).
        for (int i = 0; i < 9; i++) tick();
        chk("pre_rst_busy", 32'(busy), 32'(1));
        chk_busy_len = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_tx", 32'(tx), 32'(0));
        chk("midrst_gid", 32'(grant_id), 32'(0));
        exp_tx  = 8'h00;
        exp_gid = 0;
        tick();
        busy_run     = 0;
        chk_busy_len = 1'b1;
        prev_send    = -1;
        chk_spacing  = 1'b1;
        data = {8'hB3, 8'h00, 8'hB1, 8'h00};
        push(1, 8'hB1);
        push(3, 8'hB3);
        rst = 1'b0;
        req = 4'b1010;
        tick();
        chk("post_rst_latency", 32'(saw_send), 32'(1));
        req[1] = 1'b0;
        wait_send(3 * FC);
        req = 4'b0000;
        wait_idle(3 * FC);
        for (int i = 0; i < 3; i++) tick();

        chk("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
